// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port bundle: word address, write data and a
// one-cycle write strobe. The loader drives it (master), the memory
// consumes it (slave).
interface imem_uart_loader_if #(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] imem_address;
    logic [31:0]       imem_data;
    logic              imem_wren;

    modport master (
        output imem_address,
        output imem_data,
        output imem_wren
    );

    modport slave (
        input imem_address,
        input imem_data,
        input imem_wren
    );
endinterface

// File: rtl/imem_uart_loader.sv
// UART 8N1 program loader for the instruction memory.
// Frame: 0xA5, count N (0 = 2^ADDR_W words), N little-endian 32-bit words,
// XOR checksum of all data bytes. Keeps the core in reset while loading and
// after any failed load; a clean load releases it.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int ADDR_W         = 7,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               uart_rx,
    imem_uart_loader_if.master imem,
    output logic               core_reset,
    output logic               load_done,
    output logic               load_error
);

    localparam int CNT_W   = $clog2(CLKS_PER_BIT + 1);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   BIT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   HALF_LAST   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_MAX = TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]         SYNC_BYTE   = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {ST_SYNC, ST_COUNT, ST_DATA, ST_CHECK, ST_DONE, ST_ERROR} state_t;

    // Receiver
    logic            r_rx_p0, r_rx_p1, r_rx_prev;
    rx_state_t       r_rx_state, w_rx_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            w_byte_done, w_stop_ok, w_byte_good, w_frame_err;
    logic [7:0]      w_rx_byte;

    // Loader
    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_count, r_index, r_addr;
    logic [1:0]        r_byte_sel;
    logic [31:0]       r_word, r_data;
    logic [7:0]        r_csum;
    logic              r_wren, r_done, r_error;
    logic [TIMER_W-1:0] r_timer;
    logic              w_active, w_timeout, w_last_word;
    logic              w_clr_flags, w_set_done, w_set_error;
    logic              w_take_count, w_take_data, w_write_word;

    assign w_rx_byte   = r_shift;
    assign w_byte_good = w_byte_done && w_stop_ok;
    assign w_frame_err = w_byte_done && !w_stop_ok;
    assign w_active    = (r_state == ST_COUNT) || (r_state == ST_DATA) || (r_state == ST_CHECK);
    assign w_timeout   = w_active && !w_byte_done && (r_timer == TIMEOUT_MAX);
    // N = 0 stores as 0, so count-1 wraps to the last address and 2^ADDR_W words load.
    assign w_last_word = (r_index == (r_count - ADDR_W'(1)));

    // Two-flop synchronizer plus one delay flop for falling-edge detection; idle line is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_p0   <= 1'b1;
            r_rx_p1   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_p0   <= uart_rx;
            r_rx_p1   <= r_rx_p0;
            r_rx_prev <= r_rx_p1;
        end
    end

    // Receiver state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    // Receiver next state; w_byte_done pulses on the mid-stop-bit sample.
    always_comb begin
        w_rx_next   = r_rx_state;
        w_byte_done = 1'b0;
        w_stop_ok   = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_prev && !r_rx_p1) w_rx_next = RX_START;
            end
            RX_START: begin
                // Line back high at mid start bit means a glitch, not a start.
                if (r_bit_cnt == HALF_LAST) w_rx_next = r_rx_p1 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (r_bit_cnt == BIT_LAST && r_bit_idx == 3'd7) w_rx_next = RX_STOP;
            end
            RX_STOP: begin
                if (r_bit_cnt == BIT_LAST) begin
                    w_rx_next   = RX_IDLE;
                    w_byte_done = 1'b1;
                    w_stop_ok   = r_rx_p1;
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    // Receiver bit timing and LSB-first shift register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    r_bit_cnt <= '0;
                    r_bit_idx <= '0;
                end
                RX_START: begin
                    r_bit_cnt <= (r_bit_cnt == HALF_LAST) ? '0 : r_bit_cnt + CNT_W'(1);
                end
                RX_DATA: begin
                    if (r_bit_cnt == BIT_LAST) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        r_shift   <= {r_rx_p1, r_shift[7:1]};
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + CNT_W'(1);
                end
                default: r_bit_cnt <= '0;
            endcase
        end
    end

    // Loader state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Loader next state and per-byte actions.
    always_comb begin
        w_state_next = r_state;
        w_clr_flags  = 1'b0;
        w_set_done   = 1'b0;
        w_set_error  = 1'b0;
        w_take_count = 1'b0;
        w_take_data  = 1'b0;
        w_write_word = 1'b0;
        case (r_state)
            ST_SYNC, ST_DONE, ST_ERROR: begin
                if (w_byte_good && w_rx_byte == SYNC_BYTE) begin
                    w_state_next = ST_COUNT;
                    w_clr_flags  = 1'b1;
                end
            end
            ST_COUNT: begin
                if (w_byte_good) begin
                    w_take_count = 1'b1;
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_byte_good) begin
                    w_take_data = 1'b1;
                    if (r_byte_sel == 2'd3) begin
                        w_write_word = 1'b1;
                        if (w_last_word) w_state_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (w_byte_good) begin
                    if (w_rx_byte == r_csum) begin
                        w_state_next = ST_DONE;
                        w_set_done   = 1'b1;
                    end else begin
                        w_state_next = ST_ERROR;
                        w_set_error  = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_SYNC;
        endcase
        // Bad stop bit or a stalled sender aborts an active load.
        if (w_active && (w_frame_err || w_timeout)) begin
            w_state_next = ST_ERROR;
            w_set_error  = 1'b1;
        end
    end

    // Word assembly, checksum, memory write port, status flags and inter-byte timer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count    <= '0;
            r_index    <= '0;
            r_byte_sel <= '0;
            r_word     <= '0;
            r_csum     <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_wren     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_timer    <= '0;
        end else begin
            r_wren <= w_write_word;
            if (w_take_count) begin
                r_count    <= ADDR_W'(w_rx_byte);
                r_index    <= '0;
                r_csum     <= '0;
                r_byte_sel <= '0;
            end
            if (w_take_data) begin
                r_word     <= {w_rx_byte, r_word[31:8]};
                r_csum     <= r_csum ^ w_rx_byte;
                r_byte_sel <= r_byte_sel + 2'd1;
            end
            if (w_write_word) begin
                r_addr  <= r_index;
                r_data  <= {w_rx_byte, r_word[31:8]};
                r_index <= r_index + ADDR_W'(1);
            end
            if (w_clr_flags) begin
                r_done  <= 1'b0;
                r_error <= 1'b0;
            end
            if (w_set_done)  r_done  <= 1'b1;
            if (w_set_error) r_error <= 1'b1;
            if (w_byte_done) begin
                r_timer <= '0;
            end else if (r_timer != TIMEOUT_MAX) begin
                r_timer <= r_timer + TIMER_W'(1);
            end
        end
    end

    assign imem.imem_address = r_addr;
    assign imem.imem_data    = r_data;
    assign imem.imem_wren    = r_wren;
    assign load_done         = r_done;
    assign load_error        = r_error;
    assign core_reset        = reset | w_active | r_error;

endmodule
